// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset vector, stall/word constants,
// exception bit positions, fetch FSM and redirect encodings.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic        Stop             = 1'b1;
   localparam logic        NoStop           = 1'b0;
   localparam logic [31:0] ZeroWord         = 32'h0000_0000;

   // Bit positions inside the stall and exception vectors
   localparam int unsigned STALL_PC = 0;
   localparam int unsigned STALL_IF = 1;
   localparam int unsigned EXC_ADEL = 1;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_WAIT = 2'b10
   } fetch_state_e;

   typedef enum logic [1:0] {
      RD_NONE   = 2'b00,
      RD_BRANCH = 2'b01,
      RD_FLUSH  = 2'b10
   } redirect_kind_e;

   // Start of the next fetch group; wraps modulo 2^32
   function automatic logic [31:0] seq_next_pc(input logic [31:0] pc,
                                                input logic [31:0] grp_bytes);
      return (pc & ~(grp_bytes - 32'd1)) + grp_bytes;
   endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect and next-PC priority select for the fetch PC.
module pc_redirect_buf
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        advance,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic [31:0] seq_pc,
   output logic [31:0] next_pc
);

   redirect_kind_e pend_kind_r;
   logic [31:0]    pend_pc_r;

   // Next PC when pc advances: live flush, then stored redirect, then branch
   always_comb begin
      next_pc = seq_pc;
      if (flush) begin
         next_pc = flush_pc;
      end else if (pend_kind_r != RD_NONE) begin
         next_pc = pend_pc_r;
      end else if (br_valid) begin
         next_pc = br_target;
      end else begin
         next_pc = seq_pc;
      end
   end

   // Redirects that arrive while pc is stuck wait here; a flush is never displaced by a branch
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pend_kind_r <= RD_NONE;
         pend_pc_r   <= ZeroWord;
      end else if (advance) begin
         pend_kind_r <= RD_NONE;
         pend_pc_r   <= ZeroWord;
      end else if (flush) begin
         pend_kind_r <= RD_FLUSH;
         pend_pc_r   <= flush_pc;
      end else if (br_valid && (pend_kind_r != RD_FLUSH)) begin
         pend_kind_r <= RD_BRANCH;
         pend_pc_r   <= br_target;
      end else begin
         pend_kind_r <= pend_kind_r;
         pend_pc_r   <= pend_pc_r;
      end
   end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: issues I-side address requests, follows redirects and
// hands each accepted (or misaligned) PC to the IF stage.
module pc_fetch_gen
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          FETCH_N  = 1,
   parameter int          STALL_W  = 6,
   parameter int          EXC_W    = 7
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [31:0]        flush_pc,
   input  logic               br_valid,
   input  logic [31:0]        br_target,
   output logic               inst_req,
   output logic [31:0]        inst_addr,
   input  logic               inst_addr_ok,
   output logic [31:0]        o_pc,
   output logic               o_valid,
   output logic [EXC_W-1:0]   o_except
);

   localparam logic [31:0] GRP_BYTES = 32'(4 * FETCH_N);

   fetch_state_e     state_r;
   logic [31:0]      pc_r;
   logic [31:0]      seq_pc_s;
   logic [31:0]      next_pc_s;
   logic             aligned_s;
   logic             req_s;
   logic             bypass_s;
   logic             hs_s;
   logic             advance_s;
   logic [EXC_W-1:0] adel_vec_s;
   logic             unused_stall_s;

   assign aligned_s      = (pc_r[1:0] == 2'b00);
   assign seq_pc_s       = seq_next_pc(pc_r, GRP_BYTES);
   assign hs_s           = req_s & inst_addr_ok;
   assign advance_s      = hs_s | bypass_s;
   assign inst_req       = req_s;
   assign inst_addr      = pc_r;
   assign unused_stall_s = ^stall;

   // Request/bypass decode; a request raised in WAIT stays up until accepted
   always_comb begin
      req_s    = 1'b0;
      bypass_s = 1'b0;
      case (state_r)
         ST_BOOT: begin
            req_s    = 1'b0;
            bypass_s = 1'b0;
         end
         ST_RUN: begin
            req_s    = (stall[STALL_PC] == NoStop) && aligned_s;
            bypass_s = (stall[STALL_PC] == NoStop) && !aligned_s;
         end
         ST_WAIT: begin
            req_s    = 1'b1;
            bypass_s = 1'b0;
         end
         default: begin
            req_s    = 1'b0;
            bypass_s = 1'b0;
         end
      endcase
   end

   // Address-error exception vector with only the AdEL bit set
   always_comb begin
      adel_vec_s           = {EXC_W{1'b0}};
      adel_vec_s[EXC_ADEL] = 1'b1;
   end

   pc_redirect_buf u_redirect (
      .clk       (clk),
      .resetn    (resetn),
      .advance   (advance_s),
      .flush     (flush),
      .flush_pc  (flush_pc),
      .br_valid  (br_valid),
      .br_target (br_target),
      .seq_pc    (seq_pc_s),
      .next_pc   (next_pc_s)
   );

   // Fetch FSM, PC register and IF-stage output register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r  <= ST_BOOT;
         pc_r     <= RESET_PC;
         o_pc     <= ZeroWord;
         o_valid  <= 1'b0;
         o_except <= {EXC_W{1'b0}};
      end else begin
         case (state_r)
            ST_BOOT: state_r <= ST_RUN;
            ST_RUN:  state_r <= (req_s && !inst_addr_ok) ? ST_WAIT : ST_RUN;
            ST_WAIT: state_r <= inst_addr_ok ? ST_RUN : ST_WAIT;
            default: state_r <= ST_BOOT;
         endcase

         if (advance_s) begin
            pc_r <= next_pc_s;
         end else begin
            pc_r <= pc_r;
         end

         // A flush kills whatever was accepted this cycle
         if (flush) begin
            o_pc     <= ZeroWord;
            o_valid  <= 1'b0;
            o_except <= {EXC_W{1'b0}};
         end else if (stall[STALL_IF] == Stop) begin
            o_pc     <= o_pc;
            o_valid  <= o_valid;
            o_except <= o_except;
         end else if (hs_s) begin
            o_pc     <= pc_r;
            o_valid  <= 1'b1;
            o_except <= {EXC_W{1'b0}};
         end else if (bypass_s) begin
            o_pc     <= pc_r;
            o_valid  <= 1'b1;
            o_except <= adel_vec_s;
         end else begin
            o_pc     <= ZeroWord;
            o_valid  <= 1'b0;
            o_except <= {EXC_W{1'b0}};
         end
      end
   end

endmodule
